// File: rtl/hdmi_vram_fill_master_if.sv
// AXI4-Lite bus bundle between the VRAM fill master and the HDMI text
// controller's register/VRAM slave port.
interface hdmi_vram_fill_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/hdmi_vram_fill_master.sv
// AXI4-Lite master that fills a run of consecutive 32-bit words in the HDMI
// text controller's register/VRAM space with an arithmetic pattern
// (init, init+step, ...) and optionally reads each word back to check it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; bus quiet
// WRITE   | awvalid/wvalid up, waiting for both handshakes (any order)
// WRESP   | bready up, waiting for the write response
// RADDR   | arvalid up with the word's address (verify runs only)
// RDATA   | rready up, comparing read data against the written pattern
// ADVANCE | step address/data/index, decide next word or finish
// FINISH  | one-cycle done pulse, busy drops
module hdmi_vram_fill_master #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 16,
    parameter int CNT_W            = 12
) (
    input  logic                        axi_aclk,
    input  logic                        axi_areset,
    input  logic                        start,
    input  logic [C_AXI_ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_W-1:0]            word_count,
    input  logic [C_AXI_DATA_WIDTH-1:0] pattern_init,
    input  logic [C_AXI_DATA_WIDTH-1:0] pattern_step,
    input  logic                        verify,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [CNT_W-1:0]            err_count,
    hdmi_vram_fill_master_if.master     m_axi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_ADVANCE,
        S_FINISH
    } state_t;

    localparam logic [C_AXI_ADDR_WIDTH-1:0] ADDR_ALIGN_MASK = ~C_AXI_ADDR_WIDTH'(3);
    localparam logic [C_AXI_ADDR_WIDTH-1:0] ADDR_STRIDE     = C_AXI_ADDR_WIDTH'(4);

    state_t                        state;
    logic [C_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [C_AXI_DATA_WIDTH-1:0]   data_q;
    logic [C_AXI_DATA_WIDTH-1:0]   step_q;
    logic [CNT_W-1:0]              count_q;
    logic [CNT_W-1:0]              idx_q;
    logic                          verify_q;
    logic                          aw_done;
    logic                          w_done;
    logic                          aw_valid_q;
    logic                          w_valid_q;
    logic                          b_ready_q;
    logic                          ar_valid_q;
    logic                          r_ready_q;

    logic                          aw_ok;
    logic                          w_ok;
    logic [CNT_W-1:0]              idx_next;

    // A channel counts as finished once its handshake happened now or earlier.
    assign aw_ok    = aw_done | (aw_valid_q & m_axi.awready);
    assign w_ok     = w_done  | (w_valid_q  & m_axi.wready);
    assign idx_next = idx_q + 1'b1;

    // Address and data come straight from the running registers, so they stay
    // stable for as long as the corresponding valid is held.
    assign m_axi.awaddr  = addr_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.wdata   = data_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.wstrb   = '1;
    assign m_axi.awvalid = aw_valid_q;
    assign m_axi.wvalid  = w_valid_q;
    assign m_axi.bready  = b_ready_q;
    assign m_axi.arvalid = ar_valid_q;
    assign m_axi.rready  = r_ready_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Fill sequencer: one FSM owning every bus control and status register.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            step_q     <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            verify_q   <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q    <= base_addr & ADDR_ALIGN_MASK;
                        data_q    <= pattern_init;
                        step_q    <= pattern_step;
                        count_q   <= word_count;
                        verify_q  <= verify;
                        idx_q     <= '0;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        error     <= 1'b0;
                        err_count <= '0;
                        busy      <= 1'b1;
                        if (word_count == '0) begin
                            state <= S_FINISH;
                        end else begin
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            state      <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    if (aw_valid_q && m_axi.awready) begin
                        aw_valid_q <= 1'b0;
                    end
                    if (w_valid_q && m_axi.wready) begin
                        w_valid_q <= 1'b0;
                    end
                    if (aw_ok && w_ok) begin
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        b_ready_q <= 1'b1;
                        state     <= S_WRESP;
                    end else begin
                        aw_done <= aw_ok;
                        w_done  <= w_ok;
                    end
                end

                S_WRESP: begin
                    if (m_axi.bvalid) begin
                        b_ready_q <= 1'b0;
                        if (m_axi.bresp != 2'b00) begin
                            error     <= 1'b1;
                            err_count <= sat_inc(err_count);
                        end
                        if (verify_q) begin
                            ar_valid_q <= 1'b1;
                            state      <= S_RADDR;
                        end else begin
                            state <= S_ADVANCE;
                        end
                    end
                end

                S_RADDR: begin
                    if (m_axi.arready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state      <= S_RDATA;
                    end
                end

                S_RDATA: begin
                    if (m_axi.rvalid) begin
                        r_ready_q <= 1'b0;
                        // A bad response and bad data on the same beat count once.
                        if (m_axi.rresp != 2'b00 || m_axi.rdata != data_q) begin
                            error     <= 1'b1;
                            err_count <= sat_inc(err_count);
                        end
                        state <= S_ADVANCE;
                    end
                end

                S_ADVANCE: begin
                    idx_q  <= idx_next;
                    addr_q <= addr_q + ADDR_STRIDE;
                    data_q <= data_q + step_q;
                    if (idx_next == count_q) begin
                        state <= S_FINISH;
                    end else begin
                        aw_valid_q <= 1'b1;
                        w_valid_q  <= 1'b1;
                        state      <= S_WRITE;
                    end
                end

                S_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_vram_fill_master.sv
// Directed bench for hdmi_vram_fill_master: a configurable stub AXI4-Lite
// slave with per-channel ready delays and injectable errors, plus a bus
// monitor that logs completed writes and counts handshakes.
module tb_hdmi_vram_fill_master;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int CW = 12;

    logic          aclk = 1'b0;
    logic          rst  = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] word_count = '0;
    logic [DW-1:0] pattern_init = '0;
    logic [DW-1:0] pattern_step = '0;
    logic          verify = 1'b0;
    logic          busy, done, error;
    logic [CW-1:0] err_count;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 aclk = ~aclk;

    hdmi_vram_fill_master_if #(.ADDR_W(AW), .DATA_W(DW)) m_axi ();

    hdmi_vram_fill_master #(
        .C_AXI_DATA_WIDTH(DW),
        .C_AXI_ADDR_WIDTH(AW),
        .CNT_W(CW)
    ) dut (
        .axi_aclk    (aclk),
        .axi_areset  (rst),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .pattern_init(pattern_init),
        .pattern_step(pattern_step),
        .verify      (verify),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_count   (err_count),
        .m_axi       (m_axi)
    );

    // ---------------- stub slave ----------------
    int          aw_delay = 0;
    int          w_delay  = 0;
    int          berr_word = -1;
    int          rcorrupt_word = -1;
    int          aw_cnt, w_cnt;
    logic        aw_got, w_got;
    logic [AW-1:0] aw_addr_l;
    logic [DW-1:0] w_data_l;
    logic [DW-1:0] mem [0:16383];
    logic        bvalid_s, rvalid_s;
    logic [1:0]  bresp_s;
    logic [DW-1:0] rdata_s;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_complete;
    logic [AW-1:0] wr_cur_addr;
    logic [DW-1:0] wr_cur_data;

    int b_cnt, r_cnt, ar_cnt, aw_cyc, ar_cyc, done_cnt, viol;

    assign m_axi.awready = m_axi.awvalid && (aw_cnt >= aw_delay);
    assign m_axi.wready  = m_axi.wvalid && (w_cnt >= w_delay);
    assign m_axi.arready = m_axi.arvalid;
    assign m_axi.bvalid  = bvalid_s;
    assign m_axi.bresp   = bresp_s;
    assign m_axi.rvalid  = rvalid_s;
    assign m_axi.rdata   = rdata_s;
    assign m_axi.rresp   = 2'b00;

    assign aw_hs = m_axi.awvalid && m_axi.awready;
    assign w_hs  = m_axi.wvalid && m_axi.wready;
    assign b_hs  = m_axi.bvalid && m_axi.bready;
    assign ar_hs = m_axi.arvalid && m_axi.arready;
    assign r_hs  = m_axi.rvalid && m_axi.rready;
    assign wr_cur_addr = aw_hs ? m_axi.awaddr : aw_addr_l;
    assign wr_cur_data = w_hs ? m_axi.wdata : w_data_l;
    assign wr_complete = (aw_got || aw_hs) && (w_got || w_hs);

    always @(posedge aclk or posedge rst) begin
        if (rst) begin
            aw_cnt   <= 0;
            w_cnt    <= 0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            bvalid_s <= 1'b0;
            bresp_s  <= 2'b00;
            rvalid_s <= 1'b0;
            rdata_s  <= '0;
        end else begin
            aw_cnt <= (m_axi.awvalid && !m_axi.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_axi.wvalid && !m_axi.wready) ? w_cnt + 1 : 0;
            if (aw_hs) aw_addr_l <= m_axi.awaddr;
            if (w_hs)  w_data_l  <= m_axi.wdata;
            if (wr_complete) begin
                mem[wr_cur_addr[AW-1:2]] <= wr_cur_data;
                bvalid_s <= 1'b1;
                bresp_s  <= (b_cnt == berr_word) ? 2'd2 : 2'd0;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end
            if (b_hs) bvalid_s <= 1'b0;
            if (ar_hs) begin
                rvalid_s <= 1'b1;
                rdata_s  <= mem[m_axi.araddr[AW-1:2]] ^ ((r_cnt == rcorrupt_word) ? 32'h1 : 32'h0);
            end
            if (r_hs) rvalid_s <= 1'b0;
        end
    end

    // ---------------- monitor ----------------
    logic          mon_clr = 1'b0;
    logic [AW-1:0] wr_addr_log [$];
    logic [DW-1:0] wr_data_log [$];
    logic          aw_pend = 1'b0, w_pend = 1'b0;
    logic [AW-1:0] aw_prev;
    logic [DW-1:0] w_prev;

    always @(posedge aclk) begin
        if (mon_clr) begin
            b_cnt <= 0; r_cnt <= 0; ar_cnt <= 0; aw_cyc <= 0; ar_cyc <= 0;
            done_cnt <= 0; viol <= 0;
            wr_addr_log.delete();
            wr_data_log.delete();
        end else begin
            if (wr_complete) begin
                wr_addr_log.push_back(wr_cur_addr);
                wr_data_log.push_back(wr_cur_data);
            end
            if (b_hs) b_cnt <= b_cnt + 1;
            if (r_hs) r_cnt <= r_cnt + 1;
            if (ar_hs) ar_cnt <= ar_cnt + 1;
            if (m_axi.awvalid) aw_cyc <= aw_cyc + 1;
            if (m_axi.arvalid) ar_cyc <= ar_cyc + 1;
            if (done) done_cnt <= done_cnt + 1;
            if ((aw_pend && m_axi.awvalid && m_axi.awaddr != aw_prev) ||
                (w_pend && m_axi.wvalid && m_axi.wdata != w_prev) ||
                (m_axi.wvalid && m_axi.wstrb != 4'hF) ||
                (m_axi.awprot != 3'b0) || (m_axi.arprot != 3'b0))
                viol <= viol + 1;
        end
        aw_pend <= m_axi.awvalid && !m_axi.awready;
        w_pend  <= m_axi.wvalid && !m_axi.wready;
        aw_prev <= m_axi.awaddr;
        w_prev  <= m_axi.wdata;
    end

    // ---------------- helpers ----------------
    task automatic clr_mon();
        @(negedge aclk);
        mon_clr = 1'b1;
        @(negedge aclk);
        mon_clr = 1'b0;
    endtask

    // Returns at the falling edge right after the start edge.
    task automatic run_start(input logic [AW-1:0] b, input logic [CW-1:0] wc,
                             input logic [DW-1:0] init, input logic [DW-1:0] step,
                             input logic v);
        @(negedge aclk);
        base_addr = b; word_count = wc; pattern_init = init;
        pattern_step = step; verify = v; start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        base_addr = 16'hDEAD; word_count = 12'hABC; pattern_init = 32'hBAD0_BAD0;
        pattern_step = 32'h1234_5678; verify = ~v;
    endtask

    task automatic wait_done(input int max, output int cyc, output bit to);
        cyc = 0;
        to  = 1'b1;
        while (cyc < max) begin
            @(posedge aclk);
            @(negedge aclk);
            cyc++;
            if (done) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge aclk);
        tests_run++;
        if ({busy, done, error, err_count} !== '0) begin
            tests_failed++;
            $display("FAIL reset_status got busy=%b done=%b error=%b err_count=%0d want all 0", busy, done, error, err_count);
        end
        tests_run++;
        if ({m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_bus_ctrl got aw/w/b/ar/r=%b want 00000",
                     {m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready});
        end
        tests_run++;
        if ({m_axi.awaddr, m_axi.araddr, m_axi.wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_addr_data got awaddr=%h araddr=%h wdata=%h want 0", m_axi.awaddr, m_axi.araddr, m_axi.wdata);
        end
        rst = 1'b0;
        repeat (2) @(negedge aclk);
    endtask

    task automatic test_plain_fill();
        logic [AW-1:0] exp_a [4] = '{16'h0000, 16'h0004, 16'h0008, 16'h000C};
        logic [DW-1:0] exp_d [4] = '{32'h41, 32'h42, 32'h43, 32'h44};
        int cyc; bit to;
        clr_mon();
        run_start(16'h0000, 12'd4, 32'h41, 32'h1, 1'b0);
        wait_done(100, cyc, to);
        tests_run++;
        if (to || cyc != 13) begin
            tests_failed++;
            $display("FAIL plain_latency got %0d cycles (timeout=%0b) want 13", cyc, to);
        end
        repeat (3) @(negedge aclk);
        tests_run++;
        if (wr_addr_log.size() != 4) begin
            tests_failed++;
            $display("FAIL plain_write_count got %0d want 4", wr_addr_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests_run++;
                if (wr_addr_log[k] !== exp_a[k] || wr_data_log[k] !== exp_d[k]) begin
                    tests_failed++;
                    $display("FAIL plain_word%0d got addr=%h data=%h want addr=%h data=%h",
                             k, wr_addr_log[k], wr_data_log[k], exp_a[k], exp_d[k]);
                end
            end
        end
        tests_run++;
        if (b_cnt != 4 || done_cnt != 1 || error !== 1'b0 || ar_cyc != 0 || viol != 0) begin
            tests_failed++;
            $display("FAIL plain_summary got b=%0d done=%0d error=%b ar_cyc=%0d viol=%0d want 4 1 0 0 0",
                     b_cnt, done_cnt, error, ar_cyc, viol);
        end
    endtask

    task automatic test_verify_fill();
        int cyc; bit to; int bad;
        clr_mon();
        run_start(16'h0000, 12'd1200, 32'h0, 32'h1, 1'b1);
        wait_done(7000, cyc, to);
        tests_run++;
        if (to || cyc != 6001) begin
            tests_failed++;
            $display("FAIL verify_latency got %0d cycles (timeout=%0b) want 6001", cyc, to);
        end
        repeat (2) @(negedge aclk);
        tests_run++;
        if (b_cnt != 1200 || r_cnt != 1200 || err_count !== 12'd0 || error !== 1'b0 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL verify_summary got b=%0d r=%0d err_count=%0d error=%b done=%0d want 1200 1200 0 0 1",
                     b_cnt, r_cnt, err_count, error, done_cnt);
        end
        bad = 0;
        for (int k = 0; k < wr_addr_log.size(); k++)
            if (wr_addr_log[k] !== AW'(4 * k) || wr_data_log[k] !== DW'(k)) bad++;
        tests_run++;
        if (bad != 0 || wr_addr_log.size() != 1200) begin
            tests_failed++;
            $display("FAIL verify_pattern got %0d bad of %0d writes want 0 bad of 1200", bad, wr_addr_log.size());
        end
    endtask

    task automatic test_zero_length();
        clr_mon();
        run_start(16'h0010, 12'd0, 32'h5, 32'h1, 1'b1);
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_cycle1 got busy=%b done=%b want 1 0", busy, done);
        end
        @(posedge aclk); @(negedge aclk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_cycle2 got busy=%b done=%b want 0 1", busy, done);
        end
        @(posedge aclk); @(negedge aclk);
        tests_run++;
        if (done !== 1'b0 || aw_cyc != 0 || ar_cyc != 0) begin
            tests_failed++;
            $display("FAIL zero_quiet got done=%b aw_cyc=%0d ar_cyc=%0d want 0 0 0", done, aw_cyc, ar_cyc);
        end
    endtask

    task automatic test_split_handshake();
        logic [2:0] exp;
        int cyc; bit to;
        for (int order = 0; order < 2; order++) begin
            aw_delay = (order == 0) ? 3 : 0;
            w_delay  = (order == 0) ? 0 : 3;
            clr_mon();
            run_start(16'h0100, 12'd1, 32'hA5A5_0000, 32'h1, 1'b0);
            tests_run++;
            if ({m_axi.awvalid, m_axi.wvalid, m_axi.bready} !== 3'b110) begin
                tests_failed++;
                $display("FAIL split%0d_c0 got aw/w/b=%b want 110", order,
                         {m_axi.awvalid, m_axi.wvalid, m_axi.bready});
            end
            for (int c = 1; c <= 4; c++) begin
                @(posedge aclk); @(negedge aclk);
                if (order == 0) exp = {(c < 4), 1'b0, (c == 4)};
                else            exp = {1'b0, (c < 4), (c == 4)};
                tests_run++;
                if ({m_axi.awvalid, m_axi.wvalid, m_axi.bready} !== exp) begin
                    tests_failed++;
                    $display("FAIL split%0d_c%0d got aw/w/b=%b want %b", order, c,
                             {m_axi.awvalid, m_axi.wvalid, m_axi.bready}, exp);
                end
            end
            wait_done(50, cyc, to);
            @(negedge aclk);
            tests_run++;
            if (to || wr_addr_log.size() != 1 || b_cnt != 1 || viol != 0) begin
                tests_failed++;
                $display("FAIL split%0d_end got timeout=%0b writes=%0d b=%0d viol=%0d want 0 1 1 0",
                         order, to, wr_addr_log.size(), b_cnt, viol);
            end else begin
                tests_run++;
                if (wr_addr_log[0] !== 16'h0100 || wr_data_log[0] !== 32'hA5A5_0000) begin
                    tests_failed++;
                    $display("FAIL split%0d_word got addr=%h data=%h want 0100 a5a50000",
                             order, wr_addr_log[0], wr_data_log[0]);
                end
            end
        end
        aw_delay = 0;
        w_delay  = 0;
    endtask

    task automatic test_error_path();
        int cyc; bit to;
        clr_mon();
        berr_word = 1;
        rcorrupt_word = 2;
        run_start(16'h0200, 12'd3, 32'h10, 32'h10, 1'b1);
        wait_done(100, cyc, to);
        tests_run++;
        if (to || cyc != 16) begin
            tests_failed++;
            $display("FAIL err_latency got %0d cycles (timeout=%0b) want 16", cyc, to);
        end
        @(negedge aclk);
        tests_run++;
        if (err_count !== 12'd2 || error !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_count got err_count=%0d error=%b want 2 1", err_count, error);
        end
        tests_run++;
        if (wr_addr_log.size() != 3 || b_cnt != 3 || ar_cnt != 3) begin
            tests_failed++;
            $display("FAIL err_all_issued got writes=%0d b=%0d ar=%0d want 3 3 3", wr_addr_log.size(), b_cnt, ar_cnt);
        end
        berr_word = -1;
        rcorrupt_word = -1;
        run_start(16'h0000, 12'd0, 32'h0, 32'h0, 1'b0);
        tests_run++;
        if (error !== 1'b0 || err_count !== 12'd0) begin
            tests_failed++;
            $display("FAIL err_clear got error=%b err_count=%0d want 0 0", error, err_count);
        end
        wait_done(10, cyc, to);
    endtask

    task automatic test_wrap_and_reset();
        logic [AW-1:0] exp_a [4] = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
        logic [DW-1:0] exp_d [4] = '{32'h100, 32'hFF, 32'hFE, 32'hFD};
        int cyc; bit to; bit found;
        clr_mon();
        run_start(16'hFFF8, 12'd4, 32'h100, 32'hFFFF_FFFF, 1'b0);
        wait_done(100, cyc, to);
        @(negedge aclk);
        tests_run++;
        if (to || wr_addr_log.size() != 4) begin
            tests_failed++;
            $display("FAIL wrap_count got writes=%0d timeout=%0b want 4 0", wr_addr_log.size(), to);
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests_run++;
                if (wr_addr_log[k] !== exp_a[k] || wr_data_log[k] !== exp_d[k]) begin
                    tests_failed++;
                    $display("FAIL wrap_word%0d got addr=%h data=%h want addr=%h data=%h",
                             k, wr_addr_log[k], wr_data_log[k], exp_a[k], exp_d[k]);
                end
            end
        end

        clr_mon();
        run_start(16'hFFF8, 12'd4, 32'h100, 32'hFFFF_FFFF, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge aclk);
            if (m_axi.awvalid && wr_addr_log.size() == 2) found = 1'b1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL rst_reach_word2 got writes=%0d awvalid=%b want word 2 in flight", wr_addr_log.size(), m_axi.awvalid);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready, busy} !== 6'b0) begin
            tests_failed++;
            $display("FAIL rst_async_drop got aw/w/b/ar/r/busy=%b want 000000",
                     {m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready, busy});
        end
        repeat (2) @(negedge aclk);
        rst = 1'b0;
        repeat (20) @(negedge aclk);
        tests_run++;
        if (done_cnt != 0 || busy !== 1'b0 || m_axi.awvalid !== 1'b0 || wr_addr_log.size() != 2) begin
            tests_failed++;
            $display("FAIL rst_idle got done=%0d busy=%b awvalid=%b writes=%0d want 0 0 0 2",
                     done_cnt, busy, m_axi.awvalid, wr_addr_log.size());
        end
        run_start(16'h0040, 12'd1, 32'h77, 32'h1, 1'b0);
        wait_done(20, cyc, to);
        tests_run++;
        if (to || cyc != 4) begin
            tests_failed++;
            $display("FAIL rst_restart got %0d cycles (timeout=%0b) want 4", cyc, to);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_plain_fill();
        test_verify_fill();
        test_zero_length();
        test_split_handshake();
        test_error_path();
        test_wrap_and_reset();
        repeat (2) @(negedge aclk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hdmi_vram_fill_master.md
# hdmi_vram_fill_master

Synthesizable AXI4-Lite master that bulk-initialises the HDMI text controller's register/VRAM space: on a start pulse it writes a run of consecutive 32-bit words with an arithmetic data pattern and, optionally, reads each word back and checks it. It sits directly upstream of the text controller's AXI4-Lite slave port and replaces bench-only write/read tasks for on-chip screen clear, fill and palette load.

## Interface
- C_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported
- C_AXI_ADDR_WIDTH, 16, AXI address width; byte addresses
- CNT_W, 12, width of word_count and err_count
- axi_aclk  in  1  the single clock for the whole block
- axi_areset  in  1  asynchronous, active-high reset; the top drives the slave's axi_aresetn from its inverse
- start  in  1  one-cycle request, accepted only in IDLE
- base_addr  in  C_AXI_ADDR_WIDTH  first byte address; bits [1:0] are ignored and forced to 0
- word_count  in  CNT_W  number of words to write
- pattern_init  in  32  data value for word 0
- pattern_step  in  32  increment added for each following word
- verify  in  1  read back and compare after each write
- busy  out  1  high while a run is active
- done  out  1  one-cycle pulse at the end of a run
- error  out  1  sticky; cleared on the next accepted start
- err_count  out  CNT_W  mismatch/response-error count; saturates
- m_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master ports, widths as for the slave

## Operation
- States: IDLE, WRITE, WRESP, RADDR, RDATA, ADVANCE, FINISH.
- IDLE to WRITE on start:
  - Latch base_addr, word_count, pattern_init, pattern_step and verify.
  - Clear error and err_count.
  - If word_count==0, go to FINISH instead. No bus traffic occurs.
- Word k uses:
  - addr = base + 4k, truncated to C_AXI_ADDR_WIDTH (wraps at 2^16).
  - data = pattern_init + k*pattern_step mod 2^32. This is kept as a running accumulator, with no multiplier.
- WRITE:
  - awvalid and wvalid rise together.
  - Each valid drops independently in the cycle after its own valid&ready edge.
  - Once both handshakes are complete, go to WRESP. The handshakes may complete in either order or in the same cycle.
  - awaddr and wdata stay stable while their valid is high.
- WRESP:
  - bready=1.
  - On bvalid: if bresp!=0, set error and increment err_count.
  - Then go to RADDR if verify, else ADVANCE.
- RADDR: arvalid=1 with araddr = the same address. On arready, go to RDATA.
- RDATA:
  - rready=1.
  - On rvalid: if rresp!=0 or rdata!=data, set error and increment err_count (at most once per read).
  - Then go to ADVANCE.
- ADVANCE:
  - k++, addr += 4, data += step.
  - If k==word_count, go to FINISH; else go to WRITE.
- FINISH: done=1 for one cycle, then go to IDLE.
- A start while busy is ignored.
- The input parameters are not sampled after the start cycle.
- awprot=arprot=0. wstrb=4'hF throughout each write.

## Timing
- Reset values:
  - State IDLE.
  - All valids and readys 0.
  - busy=done=error=0, err_count=0.
  - awaddr, araddr and wdata are 0.
- Reset mid-run: the bus valids drop asynchronously and the run is abandoned. No done pulse is issued.
- busy rises in the cycle after start is accepted. It falls in the same cycle done pulses.
- Zero-wait slave, per word: WRITE 1 cycle, WRESP 1 cycle, ADVANCE 1 cycle. That gives 3 cycles per word, or 5 with verify.
- The first awvalid is asserted 1 cycle after the start edge.
- Slave stalls of any length on any channel are tolerated. There is no timeout.
- err_count saturates at 2^CNT_W-1. error stays set until the next accepted start.

## Test plan
- Plain fill, word_count=4:
  - Stimulus: base=0x0000, init=0x41, step=1, verify=0.
  - Required: writes 0x41..0x44 to addresses 0x0,0x4,0x8,0xC.
  - Required: exactly 4 B handshakes, one done pulse, error=0.
- Verify against the text controller slave:
  - Stimulus: word_count=1200, init=0, step=1, verify=1.
  - Required: 1200 write/read pairs, err_count=0, done once.
- Zero length:
  - Stimulus: start with word_count=0.
  - Required: no awvalid or arvalid ever asserted.
  - Required: done exactly 2 cycles after start, busy high for 1 cycle.
- Split handshakes with a stub slave:
  - Stimulus: wready 3 cycles before awready, then the reverse order.
  - Required: each valid drops independently and bready rises only after both handshakes complete.
- Error path with a stub slave:
  - Stimulus: bresp=2 on word 1, corrupt rdata on word 2, word_count=3.
  - Required: err_count=2, error=1, all 3 words still issued.
  - Required: a new start clears error and err_count.
- Address wrap and reset:
  - Stimulus: base=0xFFF8, word_count=4, step=0xFFFFFFFF.
  - Required: addresses 0xFFF8,0xFFFC,0x0000,0x0004.
  - Required: data runs init, init-1, and so on.
  - Stimulus: assert axi_areset during word 2.
  - Required: valids drop at once, no done pulse, idle after release.
